// File: rtl/pp_sum_sched.sv
// rtl/pp_sum_sched.sv - partial-product collector and settle/capture scheduler for the 15-operand adder
// Optional macro: PP_SUM_SCHED_DBL_BUF_EN (ping-pong operand banks)
module pp_sum_sched #(
  parameter int SIZE       = 43,
  parameter int RADIX      = 78,
  parameter int NUM_PP     = 15,
  parameter int SETTLE_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pp_valid,
  output logic                     pp_ready,
  input  logic [SIZE-1:0]          pp_data,
  input  logic                     pp_last,
  output logic [NUM_PP*SIZE-1:0]   add_a,
  input  logic [2*RADIX-1:0]       add_res_0,
  input  logic [2*RADIX-1:0]       add_res_1,
  input  logic [2*RADIX-1:0]       add_res_2,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [2*RADIX-1:0]       res_0,
  output logic [2*RADIX-1:0]       res_1,
  output logic [2*RADIX-1:0]       res_2,
  output logic                     busy,
  output logic                     seq_err
);

  localparam int RW = 2 * RADIX;
`ifdef PP_SUM_SCHED_DBL_BUF_EN
  localparam int   NB  = 2;
  localparam logic DBL = 1'b1;
`else
  localparam int   NB  = 1;
  localparam logic DBL = 1'b0;
`endif
  localparam logic [3:0] LAST_IDX  = 4'(NUM_PP - 1);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);

  typedef enum logic [1:0] {COLLECT, SETTLE, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             count_q, count_d;
  logic [3:0]             settle_q, settle_d;
  // full_q marks a bank holding a complete frame not yet handed downstream
  logic [NB-1:0]          full_q, full_d;
  // fill_q: bank being written; fly_q: bank presented to the adder
  logic                   fill_q, fill_d;
  logic                   fly_q, fly_d;
  logic                   seq_err_q, seq_err_d;
  logic [NUM_PP*SIZE-1:0] bank_q [NB];
  logic [RW-1:0]          res0_q, res1_q, res2_q;

  logic accept, at_last, frame_ok, frame_err, capture;

  assign pp_ready  = !full_q[fill_q];
  assign accept    = pp_valid && pp_ready;
  assign at_last   = (count_q == LAST_IDX);
  assign frame_ok  = accept && pp_last && at_last;
  assign frame_err = accept && (pp_last != at_last);
  assign capture   = (state_q == SETTLE) && (settle_q == 4'd1);

  assign add_a     = bank_q[fly_q];
  assign res_valid = (state_q == HOLD);
  assign res_0     = res0_q;
  assign res_1     = res1_q;
  assign res_2     = res2_q;
  assign busy      = (state_q != COLLECT) || (count_q != 4'd0);
  assign seq_err   = seq_err_q;

  // Next-state: word counting, framing check, bank ownership and settle sequencing
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    settle_d  = settle_q;
    full_d    = full_q;
    fill_d    = fill_q;
    fly_d     = fly_q;
    seq_err_d = frame_err;

    if (accept) begin
      count_d = (frame_ok || frame_err) ? 4'd0 : count_q + 4'd1;
    end
    if (frame_ok) begin
      full_d[fill_q] = 1'b1;
      fill_d         = fill_q ^ DBL;
    end

    case (state_q)
      COLLECT: begin
        // Start settling as soon as the in-flight bank is complete; the bypass
        // avoids a dead cycle when the frame finishes into the idle bank.
        if (full_q[fly_q] || (frame_ok && (fill_q == fly_q))) begin
          state_d  = SETTLE;
          settle_d = SETTLE_LD;
        end
      end
      SETTLE: begin
        settle_d = settle_q - 4'd1;
        if (settle_q == 4'd1) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          full_d[fly_q] = 1'b0;
          fly_d         = fly_q ^ DBL;
          // With two banks, a frame already waiting goes straight to settling
          if (DBL && full_q[fly_q ^ DBL]) begin
            state_d  = SETTLE;
            settle_d = SETTLE_LD;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      count_q   <= 4'd0;
      settle_q  <= 4'd0;
      full_q    <= '0;
      fill_q    <= 1'b0;
      fly_q     <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      settle_q  <= settle_d;
      full_q    <= full_d;
      fill_q    <= fill_d;
      fly_q     <= fly_d;
      seq_err_q <= seq_err_d;
    end
  end

  // Operand bank write: word k lands in slot k of the bank being filled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NB; b++) begin
        bank_q[b] <= '0;
      end
    end else if (accept) begin
      bank_q[fill_q][count_q*SIZE +: SIZE] <= pp_data;
    end
  end

  // Result capture at the end of the settle window; held through HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res0_q <= '0;
      res1_q <= '0;
      res2_q <= '0;
    end else if (capture) begin
      res0_q <= add_res_0;
      res1_q <= add_res_1;
      res2_q <= add_res_2;
    end
  end

endmodule

// File: tb/tb_pp_sum_sched.sv
// tb/tb_pp_sum_sched.sv - directed self-checking bench for pp_sum_sched
module tb_pp_sum_sched;

  localparam int SIZE   = 43;
  localparam int RADIX  = 78;
  localparam int NUM_PP = 15;
  localparam int RW     = 2 * RADIX;
  localparam int AW     = NUM_PP * SIZE;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            pp_valid;
  logic            pp_ready;
  logic [SIZE-1:0] pp_data;
  logic            pp_last;
  logic [AW-1:0]   add_a;
  logic [RW-1:0]   add_res_0, add_res_1, add_res_2;
  logic            res_valid;
  logic            res_ready;
  logic [RW-1:0]   res_0, res_1, res_2;
  logic            busy;
  logic            seq_err;

  logic [RW-1:0]   noise;
  logic [SIZE-1:0] frame_w [NUM_PP];
  logic [RW-1:0]   r0c;
  int              checks = 0;
  int              errors = 0;

  pp_sum_sched #(.SIZE(SIZE), .RADIX(RADIX), .NUM_PP(NUM_PP), .SETTLE_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .pp_valid(pp_valid), .pp_ready(pp_ready), .pp_data(pp_data), .pp_last(pp_last),
    .add_a(add_a), .add_res_0(add_res_0), .add_res_1(add_res_1), .add_res_2(add_res_2),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_0(res_0), .res_1(res_1), .res_2(res_2),
    .busy(busy), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  // Adder model: operand j of a group weighted by 2^(17*j); noise perturbs it on demand
  function automatic logic [RW-1:0] adder_grp(input logic [AW-1:0] a, input int g);
    logic [RW-1:0] s;
    s = '0;
    for (int j = 0; j < 5; j++) s = s + (RW'(a[(5*g+j)*SIZE +: SIZE]) << (17*j));
    return s;
  endfunction

  assign add_res_0 = adder_grp(add_a, 0) ^ noise;
  assign add_res_1 = adder_grp(add_a, 1) ^ noise;
  assign add_res_2 = adder_grp(add_a, 2) ^ noise;

  function automatic logic [RW-1:0] exp_grp(input int g);
    logic [RW-1:0] s;
    s = '0;
    for (int j = 0; j < 5; j++) s = s + (RW'(frame_w[5*g+j]) << (17*j));
    return s;
  endfunction

  function automatic logic [AW-1:0] exp_bank();
    logic [AW-1:0] b;
    for (int k = 0; k < NUM_PP; k++) b[k*SIZE +: SIZE] = frame_w[k];
    return b;
  endfunction

  task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [SIZE-1:0] d, input logic last);
    int n;
    n = 0;
    pp_valid = 1'b1;
    pp_data  = d;
    pp_last  = last;
    while (!pp_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("pp_ready_wait", AW'(pp_ready), AW'(1));
    tick();
    pp_valid = 1'b0;
    pp_last  = 1'b0;
  endtask

  task automatic send_frame(input int nwords, input int last_idx);
    for (int k = 0; k < nwords; k++) send_word(frame_w[k], k == last_idx);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_pp_ready"}, AW'(pp_ready), AW'(1));
    check({pfx, "_res_valid"}, AW'(res_valid), AW'(0));
    check({pfx, "_res_0"}, AW'(res_0), AW'(0));
    check({pfx, "_res_1"}, AW'(res_1), AW'(0));
    check({pfx, "_res_2"}, AW'(res_2), AW'(0));
    check({pfx, "_add_a"}, add_a, AW'(0));
    check({pfx, "_busy"}, AW'(busy), AW'(0));
    check({pfx, "_seq_err"}, AW'(seq_err), AW'(0));
  endtask

  // Result appears SETTLE_CYC+1 = 3 cycles after the accept cycle, i.e. after two more edges
  task automatic check_result(input string pfx);
    check({pfx, "_lat0"}, AW'(res_valid), AW'(0));
    tick();
    check({pfx, "_lat1"}, AW'(res_valid), AW'(0));
    tick();
    check({pfx, "_lat2"}, AW'(res_valid), AW'(1));
    check({pfx, "_res_0"}, AW'(res_0), AW'(exp_grp(0)));
    check({pfx, "_res_1"}, AW'(res_1), AW'(exp_grp(1)));
    check({pfx, "_res_2"}, AW'(res_2), AW'(exp_grp(2)));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    pp_valid  = 1'b0;
    pp_data   = '0;
    pp_last   = 1'b0;
    res_ready = 1'b1;
    noise     = '0;
    #2;
    check_reset_outputs("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Frame 1: words k+1, immediate downstream accept
    for (int k = 0; k < NUM_PP; k++) frame_w[k] = SIZE'(k + 1);
    r0c = RW'(1) + (RW'(2) << 17) + (RW'(3) << 34) + (RW'(4) << 51) + (RW'(5) << 68);
    send_frame(15, 14);
    check("t1_pp_ready_low", AW'(pp_ready), AW'(0));
    check("t1_busy", AW'(busy), AW'(1));
    check("t1_add_a", add_a, exp_bank());
    check_result("t1");
    check("t1_res_0_const", AW'(res_0), AW'(r0c));
    tick();
    check("t1_valid_one_cycle", AW'(res_valid), AW'(0));
    check("t1_pp_ready_back", AW'(pp_ready), AW'(1));
    check("t1_busy_idle", AW'(busy), AW'(0));

    // Frame 2: downstream stalls 10 cycles; adder output is perturbed while held
    res_ready = 1'b0;
    send_frame(15, 14);
    check_result("t2");
    noise = {RW{1'b1}};
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t2_hold_valid", AW'(res_valid), AW'(1));
      check("t2_hold_ready", AW'(pp_ready), AW'(0));
      check("t2_hold_res_0", AW'(res_0), AW'(r0c));
      check("t2_hold_res_2", AW'(res_2), AW'(exp_grp(2)));
    end
    noise = '0;
    res_ready = 1'b1;
    tick();
    check("t2_valid_drop", AW'(res_valid), AW'(0));
    check("t2_pp_ready_back", AW'(pp_ready), AW'(1));

    // Early pp_last on word 6
    send_frame(7, 6);
    check("t3_seq_err", AW'(seq_err), AW'(1));
    check("t3_busy", AW'(busy), AW'(0));
    check("t3_pp_ready", AW'(pp_ready), AW'(1));
    tick();
    check("t3_seq_err_pulse", AW'(seq_err), AW'(0));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_no_result", AW'(res_valid), AW'(0));
    end

    // Clean all-ones frame after the drop
    for (int k = 0; k < NUM_PP; k++) frame_w[k] = {SIZE{1'b1}};
    send_frame(15, 14);
    check("t3b_add_a", add_a, exp_bank());
    check_result("t3b");
    tick();

    // Missing pp_last on word 14
    for (int k = 0; k < NUM_PP; k++) frame_w[k] = SIZE'(k * 5 + 3);
    send_frame(15, -1);
    check("t4_seq_err", AW'(seq_err), AW'(1));
    check("t4_busy", AW'(busy), AW'(0));
    tick();
    check("t4_seq_err_pulse", AW'(seq_err), AW'(0));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_no_result", AW'(res_valid), AW'(0));
    end

    // Reset mid-SETTLE, then a normal frame
    for (int k = 0; k < NUM_PP; k++) frame_w[k] = SIZE'(k * 3 + 7);
    send_frame(15, 14);
    tick();
    check("t5_in_settle", AW'(busy), AW'(1));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_async");
    #3;
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < NUM_PP; k++) frame_w[k] = SIZE'(k * 1000 + 12345);
    send_frame(15, 14);
    check_result("t5b");
    tick();
    check("t5b_valid_drop", AW'(res_valid), AW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
